// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // One spare bit beyond clog2 keeps WIDTH=1 representable.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/fs_cell.sv
// 1-bit combinational full subtractor: D = A - B - Bin, Bout = borrow.
module fs_cell (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic             brw_q, brw_d, bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_d, cell_bout;

  fs_cell u_cell (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (brw_q),
    .D    (cell_d),
    .Bout (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = borrow_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Shift via a widened concat so the form stays legal at WIDTH=1.
        res_d = WIDTH'({cell_d, res_q} >> 1);
        brw_d = cell_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = res_d;
          bout_d  = cell_bout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 builds).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, bin;
  logic [7:0] a, b;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       start1, a1, b1, bin1;
  logic       busy1, done1, diff1, bout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(bin),
    .busy(busy), .done(done), .diff(diff), .borrow_out(bout)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  // Reference: plain (WIDTH+1)-bit arithmetic; top bit is the borrow.
  function automatic logic [8:0] ref_sub8(logic [7:0] x, logic [7:0] y, logic c);
    return {1'b0, x} - {1'b0, y} - {8'b0, c};
  endfunction

  function automatic logic [1:0] ref_sub1(logic x, logic y, logic c);
    return {1'b0, x} - {1'b0, y} - {1'b0, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Runs one WIDTH=8 operation; lat counts negedges after the accept edge until done.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                      output logic [7:0] od, output logic obo, output int lat, output int busyc);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 0; busyc = 0;
    while (!done && lat < 50) begin
      if (busy) busyc++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) begin
      errors++;
      $display("FAIL timeout8 actual=no_done required=done");
    end
    od = diff; obo = bout;
  endtask

  task automatic run1(input logic ia, input logic ib, input logic ibin,
                      output logic od, output logic obo, output int lat);
    @(negedge clk);
    a1 = ia; b1 = ib; bin1 = ibin; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) begin
      errors++;
      $display("FAIL timeout1 actual=no_done required=done");
    end
    od = diff1; obo = bout1;
  endtask

  initial begin
    vec_t       tbl[7];
    logic [7:0] d;
    logic       bo;
    int         lat, busyc, dones;
    logic [8:0] r9;
    logic [1:0] r2;
    logic [7:0] opa[32], opb[32];
    logic       opc[32];

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    tbl[4] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};

    rst = 1'b1; start = 1'b0; a = 8'hA5; b = 8'h5A; bin = 1'b1;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_bout", 32'(bout), 32'd0);
    rst = 1'b0; start = 1'b0;

    for (int unsigned i = 0; i < 7; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].bin, d, bo, lat, busyc);
      chk($sformatf("tbl%0d_diff", i), 32'(d), 32'(tbl[i].diff));
      chk($sformatf("tbl%0d_bout", i), 32'(bo), 32'(tbl[i].bout));
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd8);
      chk($sformatf("tbl%0d_busy_cycles", i), 32'(busyc), 32'd8);
    end

    for (int unsigned i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      r9 = ref_sub8(ra, rb, rc);
      run8(ra, rb, rc, d, bo, lat, busyc);
      chk($sformatf("rnd%0d_diff", i), 32'(d), 32'(r9[7:0]));
      chk($sformatf("rnd%0d_bout", i), 32'(bo), 32'(r9[8]));
    end

    // start held high; operands scrambled every cycle. Accepts at edges 0,10,20,30.
    @(negedge clk);
    for (int j = 0; j < 32; j++) begin
      if (j == 9 || j == 19 || j == 29) begin
        r9 = ref_sub8(opa[j-9], opb[j-9], opc[j-9]);
        chk($sformatf("held_done_%0d", j), 32'(done), 32'd1);
        chk($sformatf("held_diff_%0d", j), 32'(diff), 32'(r9[7:0]));
        chk($sformatf("held_bout_%0d", j), 32'(bout), 32'(r9[8]));
      end else if (done) begin
        errors++; checks++;
        $display("FAIL held_done_%0d actual=1 required=0", j);
      end
      if (j == 0) begin
        opa[j] = 8'h5A; opb[j] = 8'h3C; opc[j] = 1'b0;
      end else begin
        opa[j] = 8'($urandom); opb[j] = 8'($urandom); opc[j] = 1'($urandom);
      end
      a = opa[j]; b = opb[j]; bin = opc[j]; start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset four cycles into an operation.
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    dones = 0;
    for (int j = 0; j < 12; j++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run8(8'hFF, 8'h01, 1'b0, d, bo, lat, busyc);
    chk("after_abort_diff", 32'(d), 32'hFE);
    chk("after_abort_bout", 32'(bo), 32'd0);

    for (int unsigned k = 0; k < 8; k++) begin
      logic [2:0] kv;
      logic       od1, ob1;
      kv = 3'(k);
      r2 = ref_sub1(kv[2], kv[1], kv[0]);
      run1(kv[2], kv[1], kv[0], od1, ob1, lat);
      chk($sformatf("w1_%0d_diff", k), 32'(od1), 32'(r2[0]));
      chk($sformatf("w1_%0d_bout", k), 32'(ob1), 32'(r2[1]));
      chk($sformatf("w1_%0d_latency", k), 32'(lat), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
